// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the write-side and read-side control stages.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 4;
  localparam int unsigned FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } fifo_state_e;

  typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_input_control_if.sv
// Producer/storage-facing signal bundle of fifo_input_control; master drives requests,
// slave (the control stage) drives the registered write port and status.
interface fifo_input_control_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);

  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              read_ack;
  logic              write_en_o;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              overflow_sticky;

  modport master (
    output write_en, data_in, read_ack,
    input  write_en_o, wr_addr, wr_data, wr_ptr, count, full, almost_full, overflow,
    input  overflow_sticky
  );

  modport slave (
    input  write_en, data_in, read_ack,
    output write_en_o, wr_addr, wr_data, wr_ptr, count, full, almost_full, overflow,
    output overflow_sticky
  );

endinterface

// File: rtl/fifo_occupancy_counter.sv
// Occupancy tracker shared by both FIFO control stages: count, full, state and,
// when FIFO_ALMOST_FULL_EN is defined, a registered almost_full flag.
module fifo_occupancy_counter
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [ADDR_W:0] o_count,
  output logic            o_full,
  output logic            o_almost_full,
  output fifo_state_e     o_state
);

  localparam int unsigned Depth = 1 << ADDR_W;

  if (AF_THRESH > Depth) begin : g_thresh_check
    $error("AF_THRESH exceeds FIFO depth");
  end

  logic [ADDR_W:0] r_count;
  logic            r_full;
  fifo_state_e     r_state;
  logic [ADDR_W:0] w_count_next;
  logic            w_full_next;

  // Callers only raise i_inc when a slot is free and i_dec when non-empty.
  assign w_count_next = r_count + (ADDR_W + 1)'(i_inc) - (ADDR_W + 1)'(i_dec);
  assign w_full_next  = (w_count_next == (ADDR_W + 1)'(Depth));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_state <= S_EMPTY;
    end else begin
      r_count <= w_count_next;
      r_full  <= w_full_next;
      if (w_count_next == '0) begin
        r_state <= S_EMPTY;
      end else if (w_full_next) begin
        r_state <= S_FULL;
      end else begin
        r_state <= S_PARTIAL;
      end
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AfThresh = (ADDR_W + 1)'(AF_THRESH);
  logic r_almost_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= AfThresh);
    end
  end

  assign o_almost_full = r_almost_full;
`else
  assign o_almost_full = 1'b0;
`endif

  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_input_control.sv
// Write-side control stage of the FIFO: registers storage write strobe/address/data,
// tracks occupancy, flags overflow. Optional almost_full via FIFO_ALMOST_FULL_EN.
module fifo_input_control
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = 14
) (
  input logic                  clk,
  input logic                  reset,
  fifo_input_control_if.slave  bus
);

  logic              r_write_en_o;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_overflow;
  logic              r_overflow_sticky;

  logic [ADDR_W:0]   w_count;
  fifo_state_e       w_state;
  logic              w_valid_read;
  logic              w_accept;

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_valid_read = bus.read_ack && (w_count != '0);
  assign w_accept     = bus.write_en && ((w_state != S_FULL) || w_valid_read);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_en_o      <= 1'b0;
      r_wr_addr         <= '0;
      r_wr_data         <= '0;
      r_wr_ptr          <= '0;
      r_overflow        <= 1'b0;
      r_overflow_sticky <= 1'b0;
    end else if (w_accept) begin
      r_write_en_o <= 1'b1;
      r_wr_addr    <= r_wr_ptr[ADDR_W-1:0];
      r_wr_data    <= bus.data_in;
      r_wr_ptr     <= r_wr_ptr + 1'b1;
      r_overflow   <= 1'b0;
    end else if (bus.write_en) begin
      r_write_en_o      <= 1'b0;
      r_overflow        <= 1'b1;
      r_overflow_sticky <= 1'b1;
    end else begin
      r_write_en_o <= 1'b0;
      r_overflow   <= 1'b0;
    end
  end

  fifo_occupancy_counter #(
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF_THRESH)
  ) u_occupancy (
    .clk           (clk),
    .reset         (reset),
    .i_inc         (w_accept),
    .i_dec         (w_valid_read),
    .o_count       (w_count),
    .o_full        (bus.full),
    .o_almost_full (bus.almost_full),
    .o_state       (w_state)
  );

  assign bus.write_en_o      = r_write_en_o;
  assign bus.wr_addr         = r_wr_addr;
  assign bus.wr_data         = r_wr_data;
  assign bus.wr_ptr          = r_wr_ptr;
  assign bus.count           = w_count;
  assign bus.overflow        = r_overflow;
  assign bus.overflow_sticky = r_overflow_sticky;

endmodule
